// File: rtl/key_extend_req_pkg.sv
// Shared traffic definitions: controller phase encodings, extend limits and
// the debounce state encoding used by the pedestrian key front end.
package key_extend_req_pkg;

   typedef enum logic [1:0] {
      HW_PASS      = 2'd0,
      HW_WARN      = 2'd1,
      CR_PASS      = 2'd2,
      PHASE_UNUSED = 2'd3
   } phase_e;

   localparam int MAX_EXT_DEFAULT  = 3;
   localparam int DEBOUNCE_DEFAULT = 20;

   typedef enum logic [1:0] {
      RELEASED    = 2'd0,
      PRESS_CHK   = 2'd1,
      PRESSED     = 2'd2,
      RELEASE_CHK = 2'd3
   } deb_state_e;

endpackage

// File: rtl/key_extend_req_debounce_fsm.sv
// Two-flop synchronizer and debounce FSM for the pedestrian key; emits the
// debounced level and a single-cycle press pulse on each qualified press.
module key_debounce_fsm
   import key_extend_req_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic Sys_CLK,
   input  logic Sys_RST,
   input  logic Key_In,
   output logic key_level,
   output logic press
);

   localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_p0;
   logic             sync_p1;
   deb_state_e       state;
   deb_state_e       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             cnt_clr;
   logic             cnt_inc;
   logic             cnt_done;

   // Stage boundary: raw key into the clock domain
   always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
      if (!Sys_RST) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
      end else begin
         sync_p0 <= Key_In;
         sync_p1 <= sync_p0;
      end
   end

   assign cnt_done = (cnt == CNT_LAST);

   always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
      if (!Sys_RST) begin
         state <= RELEASED;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (cnt_clr) begin
            cnt <= '0;
         end else if (cnt_inc) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      case (state)
         RELEASED: begin
            if (sync_p1) begin
               state_nxt = PRESS_CHK;
               cnt_clr   = 1'b1;
            end
         end
         PRESS_CHK: begin
            if (!sync_p1) begin
               state_nxt = RELEASED;
            end else if (cnt_done) begin
               state_nxt = PRESSED;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         PRESSED: begin
            if (!sync_p1) begin
               state_nxt = RELEASE_CHK;
               cnt_clr   = 1'b1;
            end
         end
         RELEASE_CHK: begin
            if (sync_p1) begin
               state_nxt = PRESSED;
            end else if (cnt_done) begin
               state_nxt = RELEASED;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         default: begin
            state_nxt = RELEASED;
         end
      endcase
   end

   // The press pulse marks only the PRESS_CHK -> PRESSED step, so a held key yields one event
   always_comb begin
      key_level = (state == PRESSED) || (state == RELEASE_CHK);
      press     = (state == PRESS_CHK) && sync_p1 && cnt_done;
   end

endmodule

// File: rtl/key_extend_req.sv
// Pedestrian extend requester: latches debounced presses and, on each
// controller tick, grants or refuses a phase extension.
module key_extend_req
   import key_extend_req_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int MAX_EXT         = MAX_EXT_DEFAULT
) (
   input  logic       Sys_CLK,
   input  logic       Sys_RST,
   input  logic       tick,
   input  logic       Key_In,
   input  logic [1:0] phase,
   input  logic       phase_start,
   output logic       extend,
   output logic       denied,
   output logic       req_pending,
   output logic [1:0] ext_used,
   output logic       key_level
);

   // ext_used is two bits wide, so the cap cannot exceed 3
   localparam logic [1:0] EXT_CAP = (MAX_EXT > 3) ? 2'd3 : 2'(MAX_EXT);

   logic press;
   logic serve;
   logic grant_ok;

   function automatic logic [1:0] sat_inc(input logic [1:0] v);
      return (v < EXT_CAP) ? v + 2'd1 : v;
   endfunction

   key_debounce_fsm #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .Sys_CLK   (Sys_CLK),
      .Sys_RST   (Sys_RST),
      .Key_In    (Key_In),
      .key_level (key_level),
      .press     (press)
   );

   always_comb begin
      serve    = tick && req_pending && !phase_start;
      grant_ok = ((phase == CR_PASS) && (ext_used < EXT_CAP)) ||
                 ((phase == HW_PASS) && (ext_used == 2'd0));
      extend   = serve && grant_ok;
      denied   = serve && !grant_ok;
   end

   // A press arriving with a tick wins over the clear, so it waits for the next tick
   always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
      if (!Sys_RST) begin
         req_pending <= 1'b0;
         ext_used    <= 2'd0;
      end else if (phase_start) begin
         req_pending <= 1'b0;
         ext_used    <= 2'd0;
      end else begin
         if (press) begin
            req_pending <= 1'b1;
         end else if (serve) begin
            req_pending <= 1'b0;
         end
         if (extend) begin
            ext_used <= sat_inc(ext_used);
         end
      end
   end

endmodule

// File: tb/tb_key_extend_req.sv
// Bench for key_extend_req: directed scenarios plus random key/phase traffic,
// every cycle checked against a run-length behavioural model.
module tb_key_extend_req;

   localparam int DEB  = 4;
   localparam int MAXE = 3;
   localparam int TPER = 10;

   logic       Sys_CLK = 1'b0;
   logic       Sys_RST = 1'b0;
   logic       tick = 1'b0;
   logic       Key_In = 1'b0;
   logic [1:0] phase = 2'd2;
   logic       phase_start = 1'b0;
   logic       extend;
   logic       denied;
   logic       req_pending;
   logic [1:0] ext_used;
   logic       key_level;

   key_extend_req #(
      .DEBOUNCE_CYCLES (DEB),
      .MAX_EXT         (MAXE)
   ) dut (
      .Sys_CLK     (Sys_CLK),
      .Sys_RST     (Sys_RST),
      .tick        (tick),
      .Key_In      (Key_In),
      .phase       (phase),
      .phase_start (phase_start),
      .extend      (extend),
      .denied      (denied),
      .req_pending (req_pending),
      .ext_used    (ext_used),
      .key_level   (key_level)
   );

   always #5 Sys_CLK = ~Sys_CLK;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int ext_seen = 0;
   int den_seen = 0;

   // Reference model: key delay line, run length of disagreeing samples, latched request
   bit h1 = 0;
   bit h2 = 0;
   int run_len = 0;
   bit m_level = 0;
   bit m_pend = 0;
   int m_used = 0;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic chkn(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs == exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk1({tag, "_extend"}, extend, 1'b0);
      chk1({tag, "_denied"}, denied, 1'b0);
      chk1({tag, "_pending"}, req_pending, 1'b0);
      chk2({tag, "_ext_used"}, ext_used, 2'd0);
      chk1({tag, "_key_level"}, key_level, 1'b0);
   endtask

   // One clock cycle: inputs are already applied (1 time unit after the rising edge)
   task automatic step();
      logic grant_ok;
      logic serve;
      logic exp_ext;
      logic exp_den;
      logic press;
      int   run_now;
      tick = ((cyc % TPER) == TPER - 1);
      if (!Sys_RST) begin
         h1 = 0; h2 = 0; run_len = 0; m_level = 0; m_pend = 0; m_used = 0;
      end
      grant_ok = ((phase == 2'd2) && (m_used < MAXE)) || ((phase == 2'd0) && (m_used == 0));
      serve    = Sys_RST && tick && m_pend && !phase_start;
      exp_ext  = serve && grant_ok;
      exp_den  = serve && !grant_ok;
      @(negedge Sys_CLK);
      chk1("extend", extend, exp_ext);
      chk1("denied", denied, exp_den);
      chk1("req_pending", req_pending, m_pend);
      chk2("ext_used", ext_used, 2'(m_used));
      chk1("key_level", key_level, m_level);
      if (extend === 1'b1) ext_seen++;
      if (denied === 1'b1) den_seen++;
      if (Sys_RST) begin
         press   = 1'b0;
         run_now = (h2 != m_level) ? run_len + 1 : 0;
         if (run_now == DEB + 1) begin
            press   = !m_level;
            m_level = !m_level;
            run_len = 0;
         end else begin
            run_len = run_now;
         end
         if (phase_start) begin
            m_pend = 0;
            m_used = 0;
         end else begin
            if (press) m_pend = 1;
            else if (serve) m_pend = 0;
            if (exp_ext) m_used = (m_used < MAXE) ? m_used + 1 : m_used;
         end
         h2 = h1;
         h1 = Key_In;
      end
      @(posedge Sys_CLK);
      #1;
      cyc++;
      phase_start = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic new_phase(input logic [1:0] p);
      phase = p;
      phase_start = 1'b1;
      step();
   endtask

   task automatic press_key();
      Key_In = 1'b1;
      run(10);
      Key_In = 1'b0;
      run(10);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish within bound");
      $fatal(1, "timeout");
   end

   initial begin
      int e0;
      int d0;
      @(posedge Sys_CLK);
      #1;
      chk_zero("reset_hold");
      run(3);
      Sys_RST = 1'b1;
      run(3);

      // Bouncing key, then a clean hold in CR_PASS
      new_phase(2'd2);
      e0 = ext_seen; d0 = den_seen;
      for (int i = 0; i < 6; i++) begin
         Key_In = (i % 2 == 0);
         step();
      end
      Key_In = 1'b1; run(10);
      Key_In = 1'b0; run(15);
      chkn("bounce_extends", ext_seen - e0, 1);
      chkn("bounce_denies", den_seen - d0, 0);
      chk2("bounce_ext_used", ext_used, 2'd1);

      // Four presses in CR_PASS: three grants then a refusal
      new_phase(2'd2);
      e0 = ext_seen; d0 = den_seen;
      for (int i = 0; i < 4; i++) begin
         press_key();
         run(5);
      end
      chkn("cr4_extends", ext_seen - e0, 3);
      chkn("cr4_denies", den_seen - d0, 1);
      chk2("cr4_ext_used_sat", ext_used, 2'd3);

      // HW_PASS allows one, HW_WARN allows none
      new_phase(2'd0);
      e0 = ext_seen; d0 = den_seen;
      press_key(); run(5);
      press_key(); run(5);
      chkn("hw_extends", ext_seen - e0, 1);
      chkn("hw_denies", den_seen - d0, 1);
      new_phase(2'd1);
      e0 = ext_seen; d0 = den_seen;
      press_key(); run(5);
      chkn("warn_extends", ext_seen - e0, 0);
      chkn("warn_denies", den_seen - d0, 1);

      // Press event lands exactly on a tick cycle
      new_phase(2'd2);
      while (cyc % TPER != 3) step();
      Key_In = 1'b1;
      e0 = ext_seen;
      run(7);
      chkn("coinc_no_extend_yet", ext_seen - e0, 0);
      chk1("coinc_pending", req_pending, 1'b1);
      run(10);
      chkn("coinc_extend_next_tick", ext_seen - e0, 1);
      Key_In = 1'b0;
      run(12);

      // phase_start coincident with tick while a request is pending
      new_phase(2'd2);
      press_key(); run(5);
      chk2("ps_ext_used_before", ext_used, 2'd1);
      while (cyc % TPER != 0) step();
      Key_In = 1'b1;
      run(9);
      chk1("ps_pending_before", req_pending, 1'b1);
      e0 = ext_seen; d0 = den_seen;
      phase = 2'd2;
      phase_start = 1'b1;
      step();
      chkn("ps_no_extend", ext_seen - e0, 0);
      chkn("ps_no_deny", den_seen - d0, 0);
      chk1("ps_pending_cleared", req_pending, 1'b0);
      chk2("ps_ext_used_cleared", ext_used, 2'd0);
      Key_In = 1'b0;
      run(12);

      // Reset during press qualification with the key held through release
      new_phase(2'd2);
      Key_In = 1'b1;
      run(4);
      Sys_RST = 1'b0;
      #1;
      chk_zero("rst_mid");
      run(3);
      Sys_RST = 1'b1;
      e0 = ext_seen;
      run(30);
      chkn("rst_requal_extends", ext_seen - e0, 1);
      chk2("rst_requal_ext_used", ext_used, 2'd1);
      Key_In = 1'b0;
      run(12);

      // Random traffic against the model
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 7) == 0) Key_In = ~Key_In;
         if ($urandom_range(0, 59) == 0) begin
            phase = 2'($urandom_range(0, 3));
            phase_start = 1'b1;
         end
         Sys_RST = ($urandom_range(0, 399) != 0);
         step();
      end
      Sys_RST = 1'b1;
      run(5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
